// File: rtl/poly_voice_alloc_mixer.sv
// Polyphonic voice allocator (MIDI note-on/off, retrigger, round-robin steal) plus saturating sample mixer.
// Optional macro POLY_CHAN_FILTER_EN: accept only messages on channel MIDI_CHANNEL.
module poly_voice_alloc_mixer #(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_W     = 8,
    parameter int OUT_W        = 12,
    parameter int MIDI_CHANNEL = 0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [23:0]                    MIDI_MSG,
    input  logic                           MIDI_MSG_RDY,
    input  logic [NUM_VOICES-1:0]          VOICE_BUSY,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] VOICE_SAMPLES,
    input  logic                           SAMPLE_TICK,
    output logic [NUM_VOICES-1:0]          VOICE_NOTE_ON,
    output logic [NUM_VOICES-1:0]          VOICE_NOTE_OFF,
    output logic [6:0]                     VOICE_NOTE,
    output logic [6:0]                     VOICE_VEL,
    output logic [NUM_VOICES-1:0]          NOTE_ON_LED,
    output logic                           MSG_DROP,
    output logic [OUT_W-1:0]               OUTDAT,
    output logic                           OUTDAT_VALID
);
    localparam int PTR_W = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    generate
        if (NUM_VOICES < 2 || MIDI_CHANNEL < 0 || MIDI_CHANNEL > 15) begin : g_bad_param
            $error("poly_voice_alloc_mixer: NUM_VOICES must be >= 2 and MIDI_CHANNEL 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DECIDE, ISSUE} alloc_state_t;
    typedef enum logic {MIDLE, ACC} mix_state_t;

    alloc_state_t state_q, state_d;
    mix_state_t   mix_q, mix_d;

    logic                  rdy_ok;
    logic [3:0]            st_q;
    logic [6:0]            note_q, vel_q;
    logic [NUM_VOICES-1:0] held, target, target_q, match, free;
    logic [6:0]            note_tab [NUM_VOICES];
    logic [PTR_W-1:0]      steal_ptr;
    logic                  steal, steal_q, is_on, is_off;

    logic [CNT_W-1:0]               cnt_q;
    logic [ACC_W-1:0]               acc_q;
    logic [NUM_VOICES*SAMPLE_W-1:0] snap_q;
    logic [OUT_W-1:0]               mix_out;
    logic                           unused_msg_bits;

`ifdef POLY_CHAN_FILTER_EN
    assign rdy_ok = MIDI_MSG_RDY && (MIDI_MSG[19:16] == 4'(MIDI_CHANNEL));
`else
    assign rdy_ok = MIDI_MSG_RDY;
`endif
    assign unused_msg_bits = ^{MIDI_MSG[19:16], MIDI_MSG[15], MIDI_MSG[7]};

    assign NOTE_ON_LED = held;
    assign is_on  = (st_q == 4'h9) && (vel_q != '0);
    assign is_off = (st_q == 4'h8) || ((st_q == 4'h9) && (vel_q == '0));

    always_comb begin
        match = '0;
        free  = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            match[i] = held[i] && (note_tab[i] == note_q);
            free[i]  = !held[i] && !VOICE_BUSY[i];
        end
        target = '0;
        steal  = 1'b0;
        if (is_on) begin
            // x & -x isolates the lowest set bit: lowest-index candidate wins
            if (|match)
                target = match & (-match);
            else if (|free)
                target = free & (-free);
            else begin
                target = NUM_VOICES'(1) << steal_ptr;
                steal  = 1'b1;
            end
        end else if (is_off) begin
            target = match;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rdy_ok) state_d = DECIDE;
            DECIDE:  state_d = ISSUE;
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= IDLE;
            st_q           <= '0;
            note_q         <= '0;
            vel_q          <= '0;
            target_q       <= '0;
            steal_q        <= 1'b0;
            held           <= '0;
            steal_ptr      <= '0;
            VOICE_NOTE_ON  <= '0;
            VOICE_NOTE_OFF <= '0;
            VOICE_NOTE     <= '0;
            VOICE_VEL      <= '0;
            MSG_DROP       <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) note_tab[i] <= '0;
        end else begin
            state_q        <= state_d;
            VOICE_NOTE_ON  <= '0;
            VOICE_NOTE_OFF <= '0;
            MSG_DROP       <= rdy_ok && (state_q != IDLE);
            case (state_q)
                IDLE: if (rdy_ok) begin
                    st_q   <= MIDI_MSG[23:20];
                    note_q <= MIDI_MSG[14:8];
                    vel_q  <= MIDI_MSG[6:0];
                end
                DECIDE: begin
                    target_q <= target;
                    steal_q  <= steal;
                end
                ISSUE: begin
                    if (is_on) begin
                        VOICE_NOTE_ON <= target_q;
                        VOICE_NOTE    <= note_q;
                        VOICE_VEL     <= vel_q;
                        held          <= held | target_q;
                        for (int unsigned i = 0; i < NUM_VOICES; i++)
                            if (target_q[i]) note_tab[i] <= note_q;
                        if (steal_q)
                            steal_ptr <= (steal_ptr == PTR_W'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
                    end else if (is_off) begin
                        VOICE_NOTE_OFF <= target_q;
                        held           <= held & ~target_q;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        if (ACC_W > OUT_W) begin : g_sat
            localparam logic [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
            assign mix_out = (acc_q > OUT_MAX) ? '1 : acc_q[OUT_W-1:0];
        end else begin : g_ext
            assign mix_out = OUT_W'(acc_q);
        end
    endgenerate

    always_comb begin
        mix_d = mix_q;
        case (mix_q)
            MIDLE:   if (SAMPLE_TICK) mix_d = ACC;
            ACC:     if (cnt_q == CNT_W'(NUM_VOICES)) mix_d = MIDLE;
            default: mix_d = MIDLE;
        endcase
    end

    // Snapshot is shifted down one voice per cycle so the adder always reads the low slot
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mix_q        <= MIDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            snap_q       <= '0;
            OUTDAT       <= '0;
            OUTDAT_VALID <= 1'b0;
        end else begin
            mix_q        <= mix_d;
            OUTDAT_VALID <= 1'b0;
            case (mix_q)
                MIDLE: if (SAMPLE_TICK) begin
                    snap_q <= VOICE_SAMPLES;
                    acc_q  <= '0;
                    cnt_q  <= '0;
                end
                ACC: begin
                    if (cnt_q == CNT_W'(NUM_VOICES)) begin
                        OUTDAT       <= mix_out;
                        OUTDAT_VALID <= 1'b1;
                    end else begin
                        acc_q  <= acc_q + ACC_W'(snap_q[SAMPLE_W-1:0]);
                        snap_q <= snap_q >> SAMPLE_W;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_voice_alloc_mixer.sv
// Bench for poly_voice_alloc_mixer: directed plus random MIDI/mix traffic against an array-based reference model.
module tb_poly_voice_alloc_mixer;
    localparam int N   = 8;
    localparam int SW  = 8;
    localparam int OW  = 12;
    localparam int OW2 = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [23:0]   midi_msg;
    logic          midi_rdy;
    logic [N-1:0]  voice_busy;
    logic [N*SW-1:0] voice_samples;
    logic          sample_tick;

    logic [N-1:0]  note_on, note_off, led, note_on_b, note_off_b, led_b;
    logic [6:0]    vnote, vvel, vnote_b, vvel_b;
    logic          drop, drop_b, valid, valid_b;
    logic [OW-1:0] outdat;
    logic [OW2-1:0] outdat_b;

    int tests = 0;
    int fails = 0;

    logic         m_held [N];
    logic [6:0]   m_note [N];
    int           m_ptr;
    logic [6:0]   m_vnote, m_vvel;

    always #5 clk = ~clk;

    poly_voice_alloc_mixer #(.NUM_VOICES(N), .SAMPLE_W(SW), .OUT_W(OW), .MIDI_CHANNEL(0)) dut (
        .CLK(clk), .RST(rst), .MIDI_MSG(midi_msg), .MIDI_MSG_RDY(midi_rdy),
        .VOICE_BUSY(voice_busy), .VOICE_SAMPLES(voice_samples), .SAMPLE_TICK(sample_tick),
        .VOICE_NOTE_ON(note_on), .VOICE_NOTE_OFF(note_off), .VOICE_NOTE(vnote), .VOICE_VEL(vvel),
        .NOTE_ON_LED(led), .MSG_DROP(drop), .OUTDAT(outdat), .OUTDAT_VALID(valid)
    );

    poly_voice_alloc_mixer #(.NUM_VOICES(N), .SAMPLE_W(SW), .OUT_W(OW2), .MIDI_CHANNEL(0)) dut_sat (
        .CLK(clk), .RST(rst), .MIDI_MSG(midi_msg), .MIDI_MSG_RDY(midi_rdy),
        .VOICE_BUSY(voice_busy), .VOICE_SAMPLES(voice_samples), .SAMPLE_TICK(sample_tick),
        .VOICE_NOTE_ON(note_on_b), .VOICE_NOTE_OFF(note_off_b), .VOICE_NOTE(vnote_b), .VOICE_VEL(vvel_b),
        .NOTE_ON_LED(led_b), .MSG_DROP(drop_b), .OUTDAT(outdat_b), .OUTDAT_VALID(valid_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_held[i] = 1'b0;
            m_note[i] = '0;
        end
        m_ptr   = 0;
        m_vnote = '0;
        m_vvel  = '0;
    endtask

    function automatic logic [N-1:0] model_led();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_held[i];
        return v;
    endfunction

    task automatic model_msg(input logic [23:0] msg, input logic [N-1:0] busy,
                             output logic [N-1:0] e_on, output logic [N-1:0] e_off);
        int st, ch, vl, v;
        logic [6:0] nt;
        st = int'(msg[23:20]);
        ch = int'(msg[19:16]);
        nt = msg[14:8];
        vl = int'(msg[6:0]);
        e_on  = '0;
        e_off = '0;
`ifdef POLY_CHAN_FILTER_EN
        if (ch != 0) return;
`else
        if (ch < 0) return;
`endif
        if (st == 9 && vl != 0) begin
            v = -1;
            for (int i = 0; i < N; i++) if (v < 0 && m_held[i] && m_note[i] == nt) v = i;
            for (int i = 0; i < N; i++) if (v < 0 && !m_held[i] && !busy[i]) v = i;
            if (v < 0) begin
                v = m_ptr;
                m_ptr = (m_ptr + 1) % N;
            end
            e_on[v]   = 1'b1;
            m_held[v] = 1'b1;
            m_note[v] = nt;
            m_vnote   = nt;
            m_vvel    = msg[6:0];
        end else if (st == 8 || st == 9) begin
            for (int i = 0; i < N; i++) if (m_held[i] && m_note[i] == nt) begin
                e_off[i]  = 1'b1;
                m_held[i] = 1'b0;
            end
        end
    endtask

    function automatic int sum_of(input logic [N*SW-1:0] s);
        int acc = 0;
        for (int i = 0; i < N; i++) acc += int'(s[i*SW +: SW]);
        return acc;
    endfunction

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic check_alloc(input logic [N-1:0] e_on, input logic [N-1:0] e_off);
        chk("note_on", 32'(note_on), 32'(e_on));
        chk("note_off", 32'(note_off), 32'(e_off));
        chk("voice_note", 32'(vnote), 32'(m_vnote));
        chk("voice_vel", 32'(vvel), 32'(m_vvel));
        chk("led", 32'(model_led()), 32'(led));
    endtask

    task automatic do_msg(input logic [23:0] msg, input logic [N-1:0] busy);
        logic [N-1:0] e_on, e_off;
        @(negedge clk);
        voice_busy = busy;
        model_msg(msg, busy, e_on, e_off);
        midi_msg = msg;
        midi_rdy = 1'b1;
        @(negedge clk);
        midi_rdy = 1'b0;
        midi_msg = 24'($urandom);
        @(negedge clk);
        chk("early_pulse", 32'(note_on | note_off), 32'd0);
        @(negedge clk);
        check_alloc(e_on, e_off);
        chk("drop_idle", 32'(drop), 32'd0);
        @(negedge clk);
        chk("pulse_width", 32'(note_on | note_off), 32'd0);
    endtask

    task automatic drop_test(input logic [23:0] m1, input logic [23:0] m2);
        logic [N-1:0] e_on, e_off;
        @(negedge clk);
        voice_busy = '0;
        model_msg(m1, '0, e_on, e_off);
        midi_msg = m1;
        midi_rdy = 1'b1;
        @(negedge clk);
        midi_msg = m2;
        @(negedge clk);
        midi_rdy = 1'b0;
        chk("msg_drop", 32'(drop), 32'd1);
        @(negedge clk);
        check_alloc(e_on, e_off);
        chk("drop_width", 32'(drop), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_second_pulse", 32'(note_on | note_off), 32'd0);
        end
    endtask

    task automatic do_mix(input logic [N*SW-1:0] s);
        int sum;
        @(negedge clk);
        voice_samples = s;
        sample_tick   = 1'b1;
        sum = sum_of(s);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            sample_tick   = (k == 3);
            voice_samples = {$urandom, $urandom};
            chk("mix_early_valid", 32'(valid), 32'd0);
        end
        @(negedge clk);
        sample_tick = 1'b0;
        chk("mix_valid", 32'(valid), 32'd1);
        chk("mix_out", 32'(outdat), 32'(sat(sum, OW)));
        chk("mix_valid_sat", 32'(valid_b), 32'd1);
        chk("mix_out_sat", 32'(outdat_b), 32'(sat(sum, OW2)));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("mix_valid_width", 32'(valid | valid_b), 32'd0);
        end
    endtask

    initial begin
        logic [N-1:0] e_on, e_off;
        logic [23:0]  m;
        logic [7:0]   stb, nb, vb;
        int           sum;

        rst = 1'b1;
        midi_msg = '0;
        midi_rdy = 1'b0;
        voice_busy = '0;
        voice_samples = '0;
        sample_tick = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_note_on", 32'(note_on | note_off), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_outdat", 32'(outdat), 32'd0);
        chk("rst_flags", 32'({valid, drop}), 32'd0);
        chk("rst_note_vel", 32'({vnote, vvel}), 32'd0);
        rst = 1'b0;

        do_msg(24'h903C40, '0);
        do_msg(24'h803C00, '0);

        for (int k = 0; k < 10; k++) do_msg({8'h90, 8'(60 + k), 8'h50}, model_led());
        do_msg(24'h903E40, model_led());
        do_msg(24'h903E00, model_led());

        drop_test(24'h904070, 24'h904170);

        do_msg(24'h913C40, '0);
        do_msg(24'h903C40, '0);
        for (int k = 0; k < 10; k++) do_msg({8'h80, 8'(60 + k), 8'h00}, '0);
        do_msg(24'h813C00, '0);

        do_mix({N{8'hFF}});
        do_mix({N{8'h00}});

        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: stb = 8'h90;
                6, 7:             stb = 8'h80;
                8:                stb = 8'hB0;
                default:          stb = 8'hE0;
            endcase
            if ($urandom_range(0, 4) == 0) stb[3:0] = 4'h1;
            nb = {1'($urandom), 7'(60 + $urandom_range(0, 9))};
            vb = ($urandom_range(0, 5) == 0) ? {1'($urandom), 7'h00} : 8'($urandom);
            do_msg({stb, nb, vb}, N'($urandom));
            if (it % 12 == 0) do_mix({$urandom, $urandom});
        end

        // MIDI message and mix tick in the same cycle
        @(negedge clk);
        m = {8'h90, 8'(61 + $urandom_range(0, 5)), 8'h33};
        voice_busy = '0;
        model_msg(m, '0, e_on, e_off);
        midi_msg = m;
        midi_rdy = 1'b1;
        voice_samples = {$urandom, $urandom};
        sum = sum_of(voice_samples);
        sample_tick = 1'b1;
        @(negedge clk);
        midi_rdy = 1'b0;
        sample_tick = 1'b0;
        @(negedge clk);
        chk("conc_early", 32'(note_on | note_off), 32'd0);
        @(negedge clk);
        check_alloc(e_on, e_off);
        for (int k = 4; k <= 9; k++) begin
            @(negedge clk);
            chk("conc_early_valid", 32'(valid), 32'd0);
        end
        @(negedge clk);
        chk("conc_valid", 32'(valid), 32'd1);
        chk("conc_out", 32'(outdat), 32'(sat(sum, OW)));

        // Reset during an allocation and a mix: both are abandoned
        @(negedge clk);
        voice_busy = '0;
        midi_msg = 24'h904550;
        midi_rdy = 1'b1;
        voice_samples = {N{8'h11}};
        sample_tick = 1'b1;
        @(negedge clk);
        midi_rdy = 1'b0;
        sample_tick = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_led", 32'(led), 32'd0);
        chk("midrst_note", 32'({vnote, vvel}), 32'd0);
        chk("midrst_outdat", 32'(outdat), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            chk("midrst_quiet", 32'({note_on, valid}), 32'd0);
        end
        for (int k = 0; k < 9; k++) do_msg({8'h90, 8'(70 + k), 8'h40}, N'(8'hFF));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
